// File: rtl/entity_tile_renderer.sv
// Tile-grid entity renderer: shadow/active tables, two-stage pixel pipeline.
// Define ENTITY_TILE_COLLISION_EN to build the per-frame collision detector.
module entity_tile_renderer #(
    parameter int                 NUM_ENT    = 9,
    parameter int                 TILE_SHIFT = 4,
    parameter logic [NUM_ENT-1:0] FLIP_MASK  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [3:0]            wr_idx,
    input  logic [13:0]           wr_data,
    input  logic [9:0]            counter_H,
    input  logic [9:0]            counter_V,
    output logic                  pix_hit,
    output logic [3:0]            pix_id,
    output logic [3:0]            pix_ch,
    output logic [TILE_SHIFT-1:0] pix_row,
    output logic [TILE_SHIFT-1:0] pix_col,
    output logic                  collision
);

    localparam logic [13:0] ENT_OFF = 14'h3C00;

    logic [13:0] r_shadow [NUM_ENT];
    logic [13:0] r_active [NUM_ENT];
    logic        r_rel;
    logic        w_fs;
    logic        w_wr;

    assign w_fs     = (counter_H == 10'd0) && (counter_V == 10'd0);
    assign wr_ready = reset && r_rel && !w_fs;
    assign w_wr     = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rel <= 1'b0;
        end else begin
            r_rel <= 1'b1;
        end
    end

    // Out-of-range indices match no channel, so such writes are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                r_shadow[i] <= ENT_OFF;
                r_active[i] <= ENT_OFF;
            end
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                if (w_wr && (wr_idx == 4'(i))) begin
                    r_shadow[i] <= wr_data;
                end
                if (w_fs) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    logic        r_val1;
    logic [9:0]  r_h1;
    logic [9:0]  r_v1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_val1 <= 1'b0;
            r_h1   <= 10'd0;
            r_v1   <= 10'd0;
        end else begin
            r_val1 <= 1'b1;
            r_h1   <= counter_H;
            r_v1   <= counter_V;
        end
    end

    // Stage 2 reads r_active after a frame-start load, so pixel (0,0) sees the new frame.
    logic       w_inr;
    logic [3:0] w_trow;
    logic [3:0] w_tcol;

    assign w_inr  = ((r_v1 >> (TILE_SHIFT + 4)) == 10'd0) &&
                    ((r_h1 >> (TILE_SHIFT + 4)) == 10'd0);
    assign w_trow = 4'(r_v1 >> TILE_SHIFT);
    assign w_tcol = 4'(r_h1 >> TILE_SHIFT);

    logic        w_hit;
    logic [3:0]  w_ch;
    logic [13:0] w_ent;
    logic        w_flip;

    always_comb begin
        w_hit  = 1'b0;
        w_ch   = 4'd0;
        w_ent  = ENT_OFF;
        w_flip = 1'b0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (r_val1 && w_inr &&
                (r_active[i][13:10] != 4'hF) &&
                (r_active[i][7:4] == w_trow) &&
                (r_active[i][3:0] == w_tcol)) begin
                w_hit  = 1'b1;
                w_ch   = 4'(i);
                w_ent  = r_active[i];
                w_flip = FLIP_MASK[i];
            end
        end
    end

    logic [TILE_SHIFT-1:0] w_r;
    logic [TILE_SHIFT-1:0] w_c;
    logic [TILE_SHIFT-1:0] w_row;
    logic [TILE_SHIFT-1:0] w_col;

    assign w_r = r_v1[TILE_SHIFT-1:0];
    assign w_c = r_h1[TILE_SHIFT-1:0];

    // Bitwise inversion of an in-tile coordinate is S-1-x.
    always_comb begin
        w_row = w_r;
        w_col = w_c;
        unique case (w_ent[9:8])
            2'b00: begin
                w_row = w_r;
                w_col = w_c;
            end
            2'b01: begin
                w_row = w_c;
                w_col = ~w_r;
            end
            2'b10: begin
                w_row = ~w_r;
                w_col = ~w_c;
            end
            2'b11: begin
                w_row = ~w_c;
                w_col = w_r;
            end
        endcase
        if (w_flip) begin
            w_col = ~w_col;
        end
    end

    logic                  r_hit;
    logic [3:0]            r_id;
    logic [3:0]            r_ch;
    logic [TILE_SHIFT-1:0] r_row;
    logic [TILE_SHIFT-1:0] r_col;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hit <= 1'b0;
            r_id  <= 4'hF;
            r_ch  <= 4'd0;
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_hit <= w_hit;
            r_id  <= w_ent[13:10];
            r_ch  <= w_ch;
            r_row <= w_hit ? w_row : '0;
            r_col <= w_hit ? w_col : '0;
        end
    end

    assign pix_hit = r_hit;
    assign pix_id  = r_id;
    assign pix_ch  = r_ch;
    assign pix_row = r_row;
    assign pix_col = r_col;

`ifdef ENTITY_TILE_COLLISION_EN
    logic w_coll;
    logic r_coll;

    always_comb begin
        w_coll = 1'b0;
        for (int i = 0; i < NUM_ENT; i++) begin
            for (int j = i + 1; j < NUM_ENT; j++) begin
                if ((r_shadow[i][13:10] != 4'hF) &&
                    (r_shadow[j][13:10] != 4'hF) &&
                    (r_shadow[i][7:0] == r_shadow[j][7:0])) begin
                    w_coll = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_coll <= 1'b0;
        end else if (w_fs) begin
            r_coll <= w_coll;
        end
    end

    assign collision = r_coll;
`else
    assign collision = 1'b0;
`endif

endmodule

// File: doc/entity_tile_renderer.md
ENTITY_TILE_RENDERER -- requirements
Module: entity_tile_renderer

Interface
REQ-001 SHALL have parameter NUM_ENT, default 9: number of entity channels (1..16).
REQ-002 SHALL have parameter TILE_SHIFT, default 4: log2 of tile edge in pixels (tile = 2^TILE_SHIFT square).
REQ-003 SHALL have parameter FLIP_MASK [NUM_ENT-1:0], default 0: bit n set = channel n mirrored horizontally after rotation.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 wr_valid  input  1  entity write request.
REQ-007 wr_ready  output  1  write accepted when wr_valid && wr_ready.
REQ-008 wr_idx  input  4  channel index to write.
REQ-009 wr_data  input  14  [13:10] entity ID, [9:8] orientation, [7:4] tile row, [3:0] tile col.
REQ-010 counter_H  input  10  current pixel column.
REQ-011 counter_V  input  10  current pixel row.
REQ-012 pix_hit  output  1  pixel covered by an active entity.
REQ-013 pix_id  output  4  ID of winning entity (4'hF when no hit).
REQ-014 pix_ch  output  4  channel index of winner (0 when no hit).
REQ-015 pix_row, pix_col  output  TILE_SHIFT each  sprite-space coordinates after orientation/flip (0 when no hit).
REQ-016 collision  output  1  sticky flag, two active entities on same tile this frame.

Function
REQ-017 Two register tables SHALL exist: shadow (written) and active (used for rendering), each NUM_ENT x 14 bits.
REQ-018 Accepted write SHALL update shadow[wr_idx]; wr_idx >= NUM_ENT SHALL be accepted and discarded.
REQ-019 Frame start SHALL be the cycle where counter_H==0 && counter_V==0; on that cycle active SHALL be loaded from shadow and wr_ready SHALL be 0; otherwise wr_ready=1.
REQ-020 Channel with ID 4'hF SHALL be inactive (never hits, never collides).
REQ-021 Pixel tile = (counter_V>>TILE_SHIFT, counter_H>>TILE_SHIFT); pixels with either tile coordinate > 15 SHALL never hit.
REQ-022 Channel hits when active and its tile row/col equal pixel tile.
REQ-023 Multiple hits SHALL resolve to lowest channel index.
REQ-024 In-tile coords r=counter_V[TILE_SHIFT-1:0], c=counter_H[TILE_SHIFT-1:0], S=2^TILE_SHIFT; orientation 00: (r,c); 01: (c,S-1-r); 10: (S-1-r,S-1-c); 11: (S-1-c,r) as (pix_row,pix_col).
REQ-025 If FLIP_MASK[winner] set, pix_col SHALL be replaced by S-1-pix_col after REQ-024.
REQ-026 Pipeline SHALL be 2 stages: outputs for counters presented in cycle t SHALL appear registered in cycle t+2; one pixel per cycle, no stalls.
REQ-027 Rendering SHALL use active table only; writes SHALL never affect pixels of the current frame.
REQ-028 A write coinciding with frame start SHALL be held off (wr_ready=0) and SHALL not be lost if the source keeps wr_valid asserted.

Reset
REQ-029 While reset==0 at a clock edge: all shadow and active entries SHALL become 14'h3C00 (ID F, inactive); pipeline SHALL clear.
REQ-030 Reset values: pix_hit=0, pix_id=4'hF, pix_ch=0, pix_row=0, pix_col=0, collision=0, wr_ready=0 during reset, 1 the cycle after release.
REQ-031 Reset mid-frame SHALL discard in-flight pixels; first valid outputs SHALL appear 2 cycles after release.

Configuration
REQ-032 Macro ENTITY_TILE_COLLISION_EN defined: at each frame-start load, collision SHALL be set one cycle later if any two active-loaded channels share row/col, and held until the next frame-start load recomputes it.
REQ-033 Macro undefined: collision SHALL be tied to 0 and no comparison logic built.

Verification
REQ-034 Reset, no writes, sweep 256x256 pixels -> pix_hit=0, pix_id=F for all outputs.
REQ-035 Write ch0 = ID 3, orient 00, tile (2,5), then frame start; TILE_SHIFT=4, pixel (H=85,V=33) -> two cycles later pix_hit=1, pix_id=3, pix_ch=0, pix_row=1, pix_col=5.
REQ-036 Same entity with orient 01, pixel (H=80,V=32) -> pix_row=0, pix_col=15; with FLIP_MASK[0]=1 -> pix_col=0.
REQ-037 ch2 ID 7 and ch5 ID 9 both at tile (4,4), frame start -> pix_id=7, pix_ch=2 on that tile; collision=1 (macro defined) or 0 (undefined).
REQ-038 Write ch1 mid-frame -> current frame unchanged, change visible only after next counter_H=0,counter_V=0; write held with wr_ready=0 at frame-start cycle then accepted next cycle.
REQ-039 Assert reset mid-frame with entities loaded -> outputs return to REQ-030 values, all channels inactive after release.
